// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch/capture stage: opcodes, dispatch
// state encoding and the packed request format carried through the FIFO.
package alu_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REQ_W  = CMD_W + DATA_W + DATA_W;  // 67

  typedef enum logic [2:0] {
    opADD  = 3'd0,
    opSUB  = 3'd1,
    opXOR  = 3'd2,
    opSLT  = 3'd3,
    opAND  = 3'd4,
    opNAND = 3'd5,
    opNOR  = 3'd6,
    opOR   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StHold   = 2'd2
  } dispatch_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  command;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
  } req_t;

endpackage

// File: rtl/alu_dispatch_fifo.sv
// Request FIFO for alu_dispatch. Power-of-two depth so pointers wrap for free;
// full/empty come straight from the registered count.
module alu_dispatch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 67
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned      PtrW      = $clog2(DEPTH);
  localparam logic [PtrW:0]    FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_dispatch.sv
// Operand dispatch and result capture around the 32-bit ALU. Requests queue in
// a FIFO, are driven one at a time onto registered ALU inputs, held for
// SETTLE_CYCLES, then result/flags are latched into a valid/ready output.
// Optional build macro: ALU_DISPATCH_ZERO_FIX_EN recomputes out_zero from the
// result for every opcode instead of passing the ALU zero flag through.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_command,
  input  logic [31:0] in_operandA,
  input  logic [31:0] in_operandB,
  output logic [2:0]  alu_command,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_command,
  output logic [31:0] out_result,
  output logic        out_carryout,
  output logic        out_zero,
  output logic        out_overflow
);

  localparam int unsigned       CntW    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0]   CntLoad = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0]   CntLast = CntW'(1);

  dispatch_state_e  state_q;
  logic [CntW-1:0]  cnt_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0] fifo_wdata, fifo_rdata;
  req_t             head;
  logic             zero_cap;

  // in_ready only looks at registered occupancy, never at out_ready or pop.
  assign in_ready   = ~fifo_full;
  assign fifo_push  = in_valid & in_ready;
  assign fifo_wdata = {in_command, in_operandA, in_operandB};
  assign head       = req_t'(fifo_rdata);

  alu_dispatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pop decision: start a request from IDLE, or chain the next one as HOLD retires.
  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      StIdle:  fifo_pop = ~fifo_empty;
      StHold:  fifo_pop = out_ready & ~fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

`ifdef ALU_DISPATCH_ZERO_FIX_EN
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
  // The ALU only reports zero for ADD/SUB; derive it from the result instead.
  assign zero_cap = (alu_result == 32'd0);
`else
  assign zero_cap = alu_zero;
`endif

  // Dispatch FSM with settle counter, ALU input registers and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_command  <= opADD;
      alu_operandA <= '0;
      alu_operandB <= '0;
      out_valid    <= 1'b0;
      out_command  <= '0;
      out_result   <= '0;
      out_carryout <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            alu_command  <= head.command;
            alu_operandA <= head.operand_a;
            alu_operandB <= head.operand_b;
            cnt_q        <= CntLoad;
            state_q      <= StSettle;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntLast) begin
            out_command  <= alu_command;
            out_result   <= alu_result;
            out_carryout <= alu_carryout;
            out_zero     <= zero_cap;
            out_overflow <= alu_overflow;
            out_valid    <= 1'b1;
            state_q      <= StHold;
          end
        end
        StHold: begin
          // ALU inputs stay frozen here; out_* hold until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (fifo_pop) begin
              alu_command  <= head.command;
              alu_operandA <= head.operand_a;
              alu_operandB <= head.operand_b;
              cnt_q        <= CntLoad;
              state_q      <= StSettle;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: a behavioural ALU closes the loop, a vector
// table covers single requests, and hand-written sequences cover backpressure,
// stalls in HOLD and reset during SETTLE.
module tb_alu_dispatch;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned LAT    = SETTLE + 1;

`ifdef ALU_DISPATCH_ZERO_FIX_EN
  localparam logic XOR_ZERO = 1'b1;
`else
  localparam logic XOR_ZERO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_command;
  logic [31:0] in_operandA, in_operandB;
  logic [2:0]  alu_command;
  logic [31:0] alu_operandA, alu_operandB, alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        out_valid, out_ready;
  logic [2:0]  out_command;
  logic [31:0] out_result;
  logic        out_carryout, out_zero, out_overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  alu_dispatch #(
    .DEPTH         (DEPTH),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_command   (in_command),
    .in_operandA  (in_operandA),
    .in_operandB  (in_operandB),
    .alu_command  (alu_command),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_command  (out_command),
    .out_result   (out_result),
    .out_carryout (out_carryout),
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; zero flag only driven for ADD/SUB.
  logic [32:0] sum;
  always_comb begin
    sum          = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_command)
      3'd0: begin
        sum          = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        alu_result   = sum[31:0];
        alu_carryout = sum[32];
        alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (sum[31] != alu_operandA[31]);
        alu_zero     = (sum[31:0] == 32'd0);
      end
      3'd1: begin
        sum          = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
        alu_result   = sum[31:0];
        alu_carryout = sum[32];
        alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (sum[31] != alu_operandA[31]);
        alu_zero     = (sum[31:0] == 32'd0);
      end
      3'd2: alu_result = alu_operandA ^ alu_operandB;
      3'd3: alu_result = {31'd0, $signed(alu_operandA) < $signed(alu_operandB)};
      3'd4: alu_result = alu_operandA & alu_operandB;
      3'd5: alu_result = ~(alu_operandA & alu_operandB);
      3'd6: alu_result = ~(alu_operandA | alu_operandB);
      default: alu_result = alu_operandA | alu_operandB;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic wait_valid(input string name, input int limit, output int lat);
    lat = 0;
    while (!out_valid && lat < limit) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: out_valid not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    in_command  = c;
    in_operandA = a;
    in_operandB = b;
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a, b, res;
    logic        c, z, o;
  } vec_t;

  vec_t vecs[11];
  logic [2:0]  bp_cmd[5];
  logic [31:0] bp_a[5], bp_b[5], bp_res[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int last;
    int seen;

    vecs[0]  = '{3'd0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'd2, 32'h1234_ABCD, 32'h1234_ABCD, 32'h0000_0000, 1'b0, XOR_ZERO, 1'b0};
    vecs[4]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF0F_FF0F, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd6, 32'h0F0F_0000, 32'h00FF_00FF, 32'hF000_FF00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 32'hA000_0005, 32'h0500_000A, 32'hA500_000F, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

    bp_cmd[0] = 3'd0; bp_a[0] = 32'h1;  bp_b[0] = 32'h2;  bp_res[0] = 32'h3;
    bp_cmd[1] = 3'd1; bp_a[1] = 32'hA;  bp_b[1] = 32'h3;  bp_res[1] = 32'h7;
    bp_cmd[2] = 3'd7; bp_a[2] = 32'hF0; bp_b[2] = 32'h0F; bp_res[2] = 32'hFF;
    bp_cmd[3] = 3'd4; bp_a[3] = 32'hFF; bp_b[3] = 32'h0F; bp_res[3] = 32'h0F;
    bp_cmd[4] = 3'd2; bp_a[4] = 32'hAA; bp_b[4] = 32'hFF; bp_res[4] = 32'h55;

    reset = 1'b1; in_valid = 1'b0; in_command = '0;
    in_operandA = '0; in_operandB = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_command", {29'd0, alu_command}, 32'd0);
    chk("rst_alu_operandA", alu_operandA, 32'd0);
    chk("rst_alu_operandB", alu_operandB, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", {29'd0, out_carryout, out_zero, out_overflow}, 32'd0);

    // Single requests from the vector table, out_ready held high
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].cmd, vecs[i].a, vecs[i].b);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid($sformatf("v%0d_valid", i), 20, lat);
      chk($sformatf("v%0d_latency", i), lat, LAT);
      chk($sformatf("v%0d_command", i), {29'd0, out_command}, {29'd0, vecs[i].cmd});
      chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d_carry", i), {31'd0, out_carryout}, {31'd0, vecs[i].c});
      chk($sformatf("v%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_overflow", i), {31'd0, out_overflow}, {31'd0, vecs[i].o});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid_clr", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: five back-to-back pushes with the consumer stalled. The
    // first is popped into the ALU registers, so the FIFO fills on the fifth.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(bp_cmd[k], bp_a[k], bp_b[k]);
      if (k == 4) chk("bp_ready_before_5th", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_full_ready_low", {31'd0, in_ready}, 32'd0);
    wait_valid("bp_first_valid", 20, lat);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_stall_result", out_result, bp_res[0]);
    chk("bp_stall_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid($sformatf("bp%0d_valid", k), 20, lat);
      chk($sformatf("bp%0d_command", k), {29'd0, out_command}, {29'd0, bp_cmd[k]});
      chk($sformatf("bp%0d_result", k), out_result, bp_res[k]);
      if (k > 0) chk($sformatf("bp%0d_gap", k), cyc - last, LAT);
      last = cyc;
      @(posedge clk);
      @(negedge clk);
      if (k == 0) chk("bp_pop_raises_ready", {31'd0, in_ready}, 32'd1);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bp_no_extra_result", seen, 0);

    // out_ready 1-0-1 across two results: second result held stable while stalled
    drive(3'd0, 32'd100, 32'd23);
    @(posedge clk);
    @(negedge clk);
    drive(3'd1, 32'd50, 32'd8);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("tg_first_valid", 20, lat);
    chk("tg_first_result", out_result, 32'd123);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid("tg_second_valid", 20, lat);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tg_hold%0d_result", k), out_result, 32'd42);
      chk($sformatf("tg_hold%0d_cmd_valid", k), {28'd0, out_command, out_valid}, 32'h3);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("tg_valid_clr", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("tg_no_repeat", seen, 0);

    // Reset while the head request settles with three more queued
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(3'd7, 32'h1 << k, 32'h100);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rs_alu_command", {29'd0, alu_command}, 32'd0);
    chk("rs_alu_operandA", alu_operandA, 32'd0);
    chk("rs_alu_operandB", alu_operandB, 32'd0);
    chk("rs_out_result", out_result, 32'd0);
    out_ready = 1'b1;
    drive(3'd0, 32'h11, 32'h22);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("rs_fresh_valid", 20, lat);
    chk("rs_fresh_latency", lat, LAT);
    chk("rs_fresh_result", out_result, 32'h33);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rs_queue_discarded", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
